muldiv_hilo: RTL

//  Multi-cycle multiply/divide unit and HI/LO register pair for the CPU datapath.

---
 rtl/muldiv_hilo_if.sv | 32 +++
 rtl/muldiv_hilo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_if.sv
// Handshake bundle between the CPU datapath and the mul/div HI/LO unit.
// master: pipeline side (start/op/operands/mt*), slave: the unit.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        output mthi, mtlo, wdata,
        input  busy, done, div_by_zero,
        input  hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        input  mthi, mtlo, wdata,
        output busy, done, div_by_zero,
        output hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO pair (1 bit per cycle).
// Ports: clk, rst_n (sync, active low), bus (slave: start/op/src_a/src_b,
//   mthi/mtlo/wdata in; busy/done/div_by_zero/hi/lo out).
// Option: define SIGNED_MULDIV_EN for signed mult/div on op[1]=1.
module muldiv_hilo #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_hilo_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE_W =
        {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W =
        {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic load, step, finish;

    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
    logic is_div_q, neg_q_q, neg_r_q, dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic done_q, dzo_q;

    // ---------------- operand conditioning ----------------
    logic sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic a_neg, b_neg;

`ifdef SIGNED_MULDIV_EN
    assign sgn = bus.op[1];
`else
    logic unused_op1;
    assign sgn        = 1'b0;
    assign unused_op1 = bus.op[1];
`endif

    assign a_neg = sgn & bus.src_a[WIDTH-1];
    assign b_neg = sgn & bus.src_b[WIDTH-1];
    assign a_mag = a_neg ? (~bus.src_a + ONE_W) : bus.src_a;
    assign b_mag = b_neg ? (~bus.src_b + ONE_W) : bus.src_b;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = CNT_INIT;
                    load    = 1'b1;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- one iteration ----------------
    // Multiply: acc_hi is the running partial sum, acc_lo holds the
    // multiplier and fills with low product bits as it shifts right.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign sum = {1'b0, acc_hi_q} +
                 (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi = sum[WIDTH:1];
    assign mul_lo = {sum[0], acc_lo_q[WIDTH-1:1]};

    // Divide: acc_hi is the remainder, acc_lo shifts the dividend out
    // and the quotient in. A zero divisor always "fits", which yields
    // an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opnd_q};
    assign ge     = (rem_sh >= {1'b0, opnd_q});
    assign div_hi = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_lo = {acc_lo_q[WIDTH-2:0], ge};

    logic [WIDTH-1:0] iter_hi, iter_lo;
    assign iter_hi = is_div_q ? div_hi : mul_hi;
    assign iter_lo = is_div_q ? div_lo : mul_lo;

    // ---------------- sign fix at writeback ----------------
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod   = {iter_hi, iter_lo};
    assign prod_s = neg_q_q ? (~prod + ONE_2W) : prod;
    assign quo_s  = dz_q    ? '1 :
                    neg_q_q ? (~iter_lo + ONE_W) : iter_lo;
    assign rem_s  = neg_r_q ? (~iter_hi + ONE_W) : iter_hi;
    assign res_hi = is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    assign res_lo = is_div_q ? quo_s : prod_s[WIDTH-1:0];

    // mt* only in an idle cycle without start; start wins.
    logic wr_ok;
    assign wr_ok = (state_q == IDLE) & ~bus.start;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= HILO_RST;
            lo_q     <= HILO_RST;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            done_q <= finish;
            dzo_q  <= finish & is_div_q & dz_q;
            if (load) begin
                acc_hi_q <= '0;
                acc_lo_q <= bus.op[0] ? a_mag : b_mag;
                opnd_q   <= bus.op[0] ? b_mag : a_mag;
                is_div_q <= bus.op[0];
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= a_neg;
                dz_q     <= (bus.src_b == '0);
            end else if (step) begin
                acc_hi_q <= iter_hi;
                acc_lo_q <= iter_lo;
            end
            if (finish) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (wr_ok) begin
                if (bus.mthi) hi_q <= bus.wdata;
                if (bus.mtlo) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy        = (state_q == CALC);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dzo_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
